keyboard_matrix_q: RTL and testbench

- Parametrised successor to the fixed PS/2-to-matrix keyboard decoder.
- Buffers incoming scancode events in a FIFO and translates each one through an external synchronous map ROM. The ROM gives {extended, code} -> (row, col).
- Holds key state in a ROWS x COLS bit matrix, enforces a minimum press duration so the emulated CPU's matrix scan sees short taps, and answers row/column probes with key_hit.
- Sits between the PS/2 front end and the machine's VIA/PSG keyboard port.

---
 rtl/keyboard_matrix_q.sv | 161 ++++++++++++++++
 tb/tb_keyboard_matrix_q.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keyboard_matrix_q.sv
// Scancode-to-matrix keyboard: queues PS/2 events, maps each one through an external ROM
// and keeps a probe-able key matrix that enforces a minimum press duration.
module keyboard_matrix_q #(
    parameter int unsigned ROWS       = 8,
    parameter int unsigned COLS       = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned MIN_HOLD   = 65536,
    parameter logic [8:0]  RST_CODE   = 9'h078,
    parameter logic [8:0]  NMI_CODE   = 9'h009,
    localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic            clk_sys,
    input  logic            reset_n,
    input  logic            key_strobe,
    input  logic            key_pressed,
    input  logic            key_extended,
    input  logic [7:0]      key_code,
    input  logic            clear_all,
    output logic [8:0]      map_addr,
    input  logic [RW+CW:0]  map_data,
    input  logic [RW-1:0]   row,
    input  logic [COLS-1:0] col,
    output logic            key_hit,
    output logic            swrst,
    output logic            swnmi,
    output logic            overflow,
    output logic            busy
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned HW = (MIN_HOLD > 0) ? $clog2(MIN_HOLD + 1) : 1;

    typedef enum logic [1:0] {StIdle, StLookup, StApply} state_e;

    state_e                    state_q, state_d;
    logic [9:0]                fifo_q [FIFO_DEPTH];
    logic [9:0]                fifo_d [FIFO_DEPTH];
    logic [AW-1:0]             wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]             rd_ptr_q, rd_ptr_d;
    logic [AW:0]               count_q, count_d;
    logic [9:0]                ev_q, ev_d;
    logic [8:0]                map_addr_q, map_addr_d;
    logic [ROWS-1:0][COLS-1:0] matrix_q, matrix_d;
    logic [COLS-1:0]           row_vec_q, row_vec_d;
    logic [HW-1:0]             hold_q, hold_d;
    logic                      swrst_q, swrst_d;
    logic                      swnmi_q, swnmi_d;
    logic                      ovf_q, ovf_d;

    logic          full, pop, push, special, map_valid;
    logic [RW-1:0] map_row;
    logic [CW-1:0] map_col;

    assign map_valid = map_data[RW+CW];
    assign map_row   = map_data[RW+CW-1:CW];
    assign map_col   = map_data[CW-1:0];
    assign full      = (count_q == (AW+1)'(FIFO_DEPTH));
    assign pop       = (state_q == StIdle) && (count_q != '0) && !clear_all;
    // A pop in the same cycle frees a slot, so a push into a full queue still succeeds.
    assign push      = key_strobe && (!full || pop) && !clear_all;
    assign special   = (ev_q[8:0] == RST_CODE) || (ev_q[8:0] == NMI_CODE);

    always_comb begin
        state_d    = state_q;
        fifo_d     = fifo_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q + (AW+1)'(push) - (AW+1)'(pop);
        ev_d       = ev_q;
        map_addr_d = map_addr_q;
        matrix_d   = matrix_q;
        hold_d     = (hold_q != '0) ? hold_q - HW'(1) : hold_q;
        swrst_d    = swrst_q;
        swnmi_d    = swnmi_q;
        ovf_d      = ovf_q | (key_strobe & ~push);
        row_vec_d  = (int'(row) < ROWS) ? matrix_q[row] : '0;

        if (push) begin
            fifo_d[wr_ptr_q] = {key_pressed, key_extended, key_code};
            wr_ptr_d         = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            ev_d       = fifo_q[rd_ptr_q];
            map_addr_d = fifo_q[rd_ptr_q][8:0];
            rd_ptr_d   = rd_ptr_q + AW'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (pop) state_d = StLookup;
            end
            StLookup: state_d = StApply;
            StApply: begin
                // Releases wait out the hold window so short taps stay visible to the scan.
                if (ev_q[9] || hold_q == '0) begin
                    if (ev_q[8:0] == RST_CODE) swrst_d = ev_q[9];
                    if (ev_q[8:0] == NMI_CODE) swnmi_d = ev_q[9];
                    if (!special && map_valid && int'(map_row) < ROWS && int'(map_col) < COLS) begin
                        matrix_d[map_row][map_col] = ev_q[9];
                    end
                    if (ev_q[9]) hold_d = HW'(MIN_HOLD);
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (clear_all) begin
            state_d  = StIdle;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            matrix_d = '0;
            hold_d   = '0;
            swrst_d  = 1'b0;
            swnmi_d  = 1'b0;
            ovf_d    = 1'b0;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            fifo_q     <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ev_q       <= '0;
            map_addr_q <= '0;
            matrix_q   <= '0;
            row_vec_q  <= '0;
            hold_q     <= '0;
            swrst_q    <= 1'b0;
            swnmi_q    <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            fifo_q     <= fifo_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ev_q       <= ev_d;
            map_addr_q <= map_addr_d;
            matrix_q   <= matrix_d;
            row_vec_q  <= row_vec_d;
            hold_q     <= hold_d;
            swrst_q    <= swrst_d;
            swnmi_q    <= swnmi_d;
            ovf_q      <= ovf_d;
        end
    end

    assign map_addr = map_addr_q;
    assign key_hit  = |(row_vec_q & ~col);
    assign swrst    = swrst_q;
    assign swnmi    = swnmi_q;
    assign overflow = ovf_q;
    assign busy     = (count_q != '0) || (state_q != StIdle);

endmodule

// File: tb/tb_keyboard_matrix_q.sv
// Bench for keyboard_matrix_q: timestamp-based event model checked every cycle plus directed
// scenarios with hand-computed expectations.
module tb_keyboard_matrix_q;
    localparam int unsigned ROWS  = 8;
    localparam int unsigned COLS  = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned HOLD  = 16;

    logic       clk_sys      = 1'b0;
    logic       reset_n      = 1'b1;
    logic       key_strobe   = 1'b0;
    logic       key_pressed  = 1'b0;
    logic       key_extended = 1'b0;
    logic [7:0] key_code     = 8'h00;
    logic       clear_all    = 1'b0;
    logic [8:0] map_addr;
    logic [6:0] map_data     = 7'd0;
    logic [2:0] row          = 3'd0;
    logic [7:0] col          = 8'hFF;
    logic       key_hit, swrst, swnmi, overflow, busy;

    int errors = 0;
    int checks = 0;

    always #5 clk_sys = ~clk_sys;

    keyboard_matrix_q #(
        .ROWS(ROWS), .COLS(COLS), .FIFO_DEPTH(DEPTH), .MIN_HOLD(HOLD)
    ) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .key_strobe(key_strobe),
        .key_pressed(key_pressed), .key_extended(key_extended), .key_code(key_code),
        .clear_all(clear_all), .map_addr(map_addr), .map_data(map_data), .row(row),
        .col(col), .key_hit(key_hit), .swrst(swrst), .swnmi(swnmi), .overflow(overflow),
        .busy(busy)
    );

    // {valid, row, col}; F11/F10 are given valid entries to show they bypass the matrix.
    function automatic logic [6:0] rom_lookup(input logic [8:0] a);
        case (a)
            9'h01C:  return {1'b1, 3'd6, 3'd5};
            9'h175:  return {1'b1, 3'd4, 3'd3};
            9'h022:  return {1'b1, 3'd2, 3'd1};
            9'h035:  return {1'b1, 3'd0, 3'd7};
            9'h015:  return {1'b1, 3'd1, 3'd0};
            9'h01D:  return {1'b1, 3'd1, 3'd1};
            9'h024:  return {1'b1, 3'd1, 3'd2};
            9'h02D:  return {1'b1, 3'd1, 3'd3};
            9'h02C:  return {1'b1, 3'd1, 3'd4};
            9'h078:  return {1'b1, 3'd7, 3'd7};
            9'h009:  return {1'b1, 3'd7, 3'd7};
            default: return 7'd0;
        endcase
    endfunction

    always @(posedge clk_sys) map_data <= rom_lookup(map_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: events wait in a queue; one in flight takes effect two edges after it is taken,
    // and a release may not take effect until MIN_HOLD+1 edges after the last press took effect.
    logic [9:0] mq[$];
    bit         m_inflight   = 1'b0;
    logic [9:0] m_ev         = '0;
    longint     edge_n       = 0;
    longint     m_pop_edge   = 0;
    longint     m_press_edge = -1000000;
    bit         m_mat [ROWS][COLS];
    logic [7:0] m_rowvec     = '0;
    logic [8:0] m_addr       = '0;
    bit         m_rst = 1'b0, m_nmi = 1'b0, m_ovf = 1'b0;

    function automatic void model_clear_keys();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) m_mat[r][c] = 1'b0;
        m_rst = 1'b0;
        m_nmi = 1'b0;
        m_ovf = 1'b0;
        m_press_edge = -1000000;
        mq.delete();
        m_inflight = 1'b0;
    endfunction

    function automatic void model_apply();
        logic [6:0] m;
        logic [8:0] a;
        bit         p;
        a = m_ev[8:0];
        p = m_ev[9];
        if (a == 9'h078) m_rst = p;
        if (a == 9'h009) m_nmi = p;
        if (a != 9'h078 && a != 9'h009) begin
            m = rom_lookup(a);
            if (m[6] && int'(m[5:3]) < ROWS && int'(m[2:0]) < COLS) m_mat[m[5:3]][m[2:0]] = p;
        end
        if (p) m_press_edge = edge_n;
    endfunction

    always @(posedge clk_sys or negedge reset_n) begin : model
        logic [7:0] rv;
        int         pre;
        bit         popped;
        if (!reset_n) begin
            model_clear_keys();
            m_rowvec = '0;
            m_addr   = '0;
        end else begin
            edge_n++;
            for (int c = 0; c < COLS; c++) rv[c] = m_mat[row][c];
            if (clear_all) begin
                model_clear_keys();
            end else begin
                pre    = mq.size();
                popped = 1'b0;
                if (m_inflight && edge_n >= m_pop_edge + 2) begin
                    if (m_ev[9] || edge_n > m_press_edge + HOLD) begin
                        model_apply();
                        m_inflight = 1'b0;
                    end
                end else if (!m_inflight && pre > 0) begin
                    m_ev       = mq.pop_front();
                    m_inflight = 1'b1;
                    m_pop_edge = edge_n;
                    m_addr     = m_ev[8:0];
                    popped     = 1'b1;
                end
                if (key_strobe) begin
                    if (pre < DEPTH || popped) mq.push_back({key_pressed, key_extended, key_code});
                    else m_ovf = 1'b1;
                end
            end
            m_rowvec = rv;
        end
    end

    always @(negedge clk_sys) begin
        check("map_addr", 32'(map_addr), 32'(m_addr));
        check("key_hit", 32'(key_hit), 32'(|(m_rowvec & ~col)));
        check("swrst", 32'(swrst), 32'(m_rst));
        check("swnmi", 32'(swnmi), 32'(m_nmi));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("busy", 32'(busy), 32'((mq.size() != 0) || m_inflight));
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic strobe(input bit p, input bit e, input logic [7:0] c);
        key_strobe   = 1'b1;
        key_pressed  = p;
        key_extended = e;
        key_code     = c;
        tick();
        key_strobe   = 1'b0;
    endtask

    task automatic probe(input logic [2:0] r, input int c);
        row = r;
        col = ~(8'd1 << c);
    endtask

    initial begin
        int e;
        #1 reset_n = 1'b0;
        #2;
        check("rst_key_hit", 32'(key_hit), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_map_addr", 32'(map_addr), 0);
        check("rst_swrst", 32'(swrst), 0);
        check("rst_overflow", 32'(overflow), 0);
        tick(2);
        reset_n = 1'b1;
        tick(1);

        // 'A' press: key_hit at strobe+5, release held off by MIN_HOLD.
        probe(3'd6, 5);
        strobe(1'b1, 1'b0, 8'h1C);
        tick(3);
        check("a_hit_t4", 32'(key_hit), 0);
        tick(1);
        check("a_hit_t5", 32'(key_hit), 1);
        strobe(1'b0, 1'b0, 8'h1C);
        e = 5;
        while (key_hit && e < 60) begin
            tick();
            e++;
        end
        check("a_release_edge", 32'(e), 21);

        // Same code, only the extended form is mapped.
        probe(3'd4, 3);
        strobe(1'b1, 1'b0, 8'h75);
        tick(5);
        check("nonext_ignored", 32'(key_hit), 0);
        strobe(1'b1, 1'b1, 8'h75);
        tick(4);
        check("ext_up_hit", 32'(key_hit), 1);

        // F11 / F10 drive swrst / swnmi and never the matrix.
        probe(3'd7, 7);
        strobe(1'b1, 1'b0, 8'h78);
        tick(2);
        check("swrst_t3", 32'(swrst), 0);
        tick(1);
        check("swrst_t4", 32'(swrst), 1);
        tick(2);
        check("f11_matrix_untouched", 32'(key_hit), 0);
        strobe(1'b0, 1'b0, 8'h78);
        tick(22);
        check("swrst_release", 32'(swrst), 0);
        strobe(1'b1, 1'b0, 8'h09);
        tick(3);
        check("swnmi_t4", 32'(swnmi), 1);
        strobe(1'b0, 1'b0, 8'h09);
        tick(22);
        check("swnmi_release", 32'(swnmi), 0);

        // X press, then X release and Y press queued behind the hold stall.
        probe(3'd2, 1);
        strobe(1'b1, 1'b0, 8'h22);
        tick(4);
        check("x_down", 32'(key_hit), 1);
        strobe(1'b0, 1'b0, 8'h22);
        strobe(1'b1, 1'b0, 8'h35);
        tick(8);
        check("x_held_in_stall", 32'(key_hit), 1);
        check("busy_in_stall", 32'(busy), 1);
        tick(6);
        probe(3'd0, 7);
        tick(1);
        check("y_not_before_x", 32'(key_hit), 0);
        check("busy_y_pending", 32'(busy), 1);
        tick(3);
        check("y_applied", 32'(key_hit), 1);
        check("busy_drained", 32'(busy), 0);

        // Stalled release plus five presses: four fit behind it, the last is dropped.
        strobe(1'b1, 1'b0, 8'h1C);
        tick(4);
        strobe(1'b0, 1'b0, 8'h1C);
        strobe(1'b1, 1'b0, 8'h15);
        strobe(1'b1, 1'b0, 8'h1D);
        strobe(1'b1, 1'b0, 8'h24);
        strobe(1'b1, 1'b0, 8'h2D);
        strobe(1'b1, 1'b0, 8'h2C);
        check("overflow_set", 32'(overflow), 1);
        check("busy_full", 32'(busy), 1);
        tick(40);
        for (int c = 0; c < 5; c++) begin
            probe(3'd1, c);
            tick(1);
            check($sformatf("row1_col%0d", c), 32'(key_hit), (c < 4) ? 1 : 0);
        end
        clear_all  = 1'b1;
        key_strobe = 1'b1;
        key_code   = 8'h15;
        tick();
        clear_all  = 1'b0;
        key_strobe = 1'b0;
        check("clear_overflow", 32'(overflow), 0);
        check("clear_busy", 32'(busy), 0);
        probe(3'd1, 0);
        tick(1);
        check("clear_matrix", 32'(key_hit), 0);

        // Asynchronous reset while an event is in APPLY with a key down.
        probe(3'd4, 3);
        strobe(1'b1, 1'b1, 8'h75);
        tick(4);
        check("pre_reset_hit", 32'(key_hit), 1);
        strobe(1'b1, 1'b0, 8'h22);
        tick(2);
        #2 reset_n = 1'b0;
        #1;
        check("async_key_hit", 32'(key_hit), 0);
        check("async_busy", 32'(busy), 0);
        check("async_map_addr", 32'(map_addr), 0);
        check("async_swrst", 32'(swrst), 0);
        check("async_overflow", 32'(overflow), 0);
        tick(1);
        reset_n = 1'b1;
        tick(1);
        strobe(1'b1, 1'b1, 8'h75);
        tick(4);
        check("post_reset_press", 32'(key_hit), 1);
        tick(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete, expected completion");
        $fatal(1);
    end
endmodule
